mod_exp_ctrl: RTL and testbench

// - Sequences one shared modular multiplier (mm_*) through left-to-right square-and-multiply to compute result = base^exp mod modulus.
// - Sits between the RSA encrypt/decrypt top level and the mod-mul datapath.
// - Latches operands on start, issues one mod-mul request at a time, and returns the result with a one-cycle done pulse.

---
 rtl/mod_exp_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared modular multiplier.
// Optional MODEXP_LZ_SKIP_EN: skip leading zero exponent bits in SCAN before the first square.
module mod_exp_ctrl #(
  parameter int WIDTH = 2048,
  parameter int CNTW  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_n,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_SQR_REQ, S_SQR_WAIT, S_MUL_REQ, S_MUL_WAIT, S_NEXT, S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] mm_a_q, mm_a_d;
  logic [WIDTH-1:0] mm_b_q, mm_b_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] exp_sh;
  logic             exp_bit;

  // Shift rather than bit-select so the index width need not match log2(WIDTH).
  assign exp_sh  = exp_q >> idx_q;
  assign exp_bit = exp_sh[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      result_q <= '0;
      mm_a_q   <= '0;
      mm_b_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      result_q <= result_d;
      mm_a_q   <= mm_a_d;
      mm_b_q   <= mm_b_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    result_d = result_q;
    mm_a_d   = mm_a_q;
    mm_b_d   = mm_b_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base;
          exp_d  = exp;
          mod_d  = modulus;
          idx_d  = CNTW'(WIDTH - 1);
          err_d  = (modulus == '0);
          acc_d  = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
          if (modulus == '0) begin
            acc_d   = '0;
            state_d = S_FIN;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
`ifdef MODEXP_LZ_SKIP_EN
        if (exp_bit) begin
          state_d = S_SQR_REQ;
        end else if (idx_q != '0) begin
          idx_d = idx_q - CNTW'(1);
        end else begin
          state_d = S_FIN;
        end
`else
        state_d = S_SQR_REQ;
`endif
      end
      S_SQR_REQ: state_d = S_SQR_WAIT;
      S_SQR_WAIT: begin
        if (mm_done) begin
          acc_d   = mm_result;
          state_d = exp_bit ? S_MUL_REQ : S_NEXT;
        end
      end
      S_MUL_REQ: state_d = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (mm_done) begin
          acc_d   = mm_result;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q - CNTW'(1);
          state_d = S_SQR_REQ;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Operands are loaded on entry to a request state and held through the wait.
    if (state_d == S_SQR_REQ && state_q != S_SQR_REQ) begin
      mm_a_d = acc_d;
      mm_b_d = acc_d;
    end
    if (state_d == S_MUL_REQ && state_q != S_MUL_REQ) begin
      mm_a_d = acc_d;
      mm_b_d = base_q;
    end
    if (state_d == S_FIN && state_q != S_FIN) begin
      result_d = acc_d;
    end
  end

  always_comb begin
    busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    done     = (state_q == S_FIN);
    mm_start = (state_q == S_SQR_REQ) || (state_q == S_MUL_REQ);
  end

  assign err    = err_q;
  assign result = result_q;
  assign mm_a   = mm_a_q;
  assign mm_b   = mm_b_q;
  assign mm_n   = mod_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl (WIDTH=16) with a 3-cycle behavioural mod-mul responder.
module tb_mod_exp_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] base, exp_v, modulus, result, mm_a, mm_b, mm_n;
  logic         busy, done, err, mm_start;
  logic         mm_done = 1'b0;
  logic [W-1:0] mm_result = '0;

  int checks = 0;
  int errors = 0;
  int mm_starts = 0;
  int dones = 0;
  int stab_bad = 0;

  logic [W-1:0] pa, pb, pn;
  int           pcnt = 0;
  logic         pend = 1'b0;

  mod_exp_ctrl #(.WIDTH(W), .CNTW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .exp(exp_v),
    .modulus(modulus), .busy(busy), .done(done), .err(err), .result(result),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_done(mm_done), .mm_result(mm_result)
  );

  always #5 clk = ~clk;

  // Multiplier responder: captures operands on mm_start, answers three cycles later.
  always @(posedge clk) begin
    mm_done <= 1'b0;
    if (mm_start) begin
      pa   <= mm_a;
      pb   <= mm_b;
      pn   <= mm_n;
      pcnt <= 3;
      pend <= 1'b1;
    end else if (pend) begin
      if (mm_a !== pa || mm_b !== pb) stab_bad <= stab_bad + 1;
      pcnt <= pcnt - 1;
      if (pcnt == 1) begin
        mm_done   <= 1'b1;
        mm_result <= (pn == '0) ? '0 : W'((32'(pa) * 32'(pb)) % 32'(pn));
        pend      <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (mm_start) mm_starts <= mm_starts + 1;
    if (done)     dones     <= dones + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint unsigned ref_pow(input longint unsigned b, input logic [W-1:0] e,
                                              input longint unsigned m);
    longint unsigned r, bb;
    if (m == 0) return 0;
    r  = 1 % m;
    bb = b % m;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * bb) % m;
      bb = (bb * bb) % m;
    end
    return r;
  endfunction

  function automatic int ref_ops(input logic [W-1:0] e, input logic [W-1:0] m);
    int bits;
    if (m == '0) return 0;
`ifdef MODEXP_LZ_SKIP_EN
    bits = 0;
    for (int i = 0; i < W; i++) if (e[i]) bits = i + 1;
`else
    bits = W;
`endif
    return bits + $countones(e);
  endfunction

  task automatic run(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                     input bit hold, input string tag, output logic [W-1:0] res);
    int s0, d0, sb0;
    bit got;
    logic [W-1:0] expect_r;
    expect_r = W'(ref_pow(longint'(b), e, longint'(m)));
    @(negedge clk);
    base = b; exp_v = e; modulus = m; start = 1'b1;
    s0 = mm_starts; d0 = dones; sb0 = stab_bad;
    @(negedge clk);
    if (!hold) start = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (hold) begin
        base  = W'($urandom);
        exp_v = W'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    chk({tag, " result"}, 64'(result), 64'(expect_r));
    chk({tag, " err"}, 64'(err), 64'(m == '0));
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    res = result;
    repeat (4) @(negedge clk);
    chk({tag, " done_count"}, 64'(dones - d0), 64'd1);
    chk({tag, " mm_starts"}, 64'(mm_starts - s0), 64'(ref_ops(e, m)));
    chk({tag, " operand_stability"}, 64'(stab_bad - sb0), 64'd0);
    chk({tag, " result_held"}, 64'(result), 64'(expect_r));
  endtask

  initial begin
    logic [W-1:0] r;
    int s0, d0;
    bit reached;
    reset = 1'b1; start = 1'b0; base = '0; exp_v = '0; modulus = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset mm_start", 64'(mm_start), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset mm_a", 64'(mm_a), 64'd0);
    chk("reset mm_b", 64'(mm_b), 64'd0);
    chk("reset mm_n", 64'(mm_n), 64'd0);
    reset = 1'b0;

    s0 = mm_starts;
    run(16'd4, 16'd13, 16'd497, 1'b0, "4^13%497", r);
    chk("4^13%497 known", 64'(r), 64'd445);
`ifdef MODEXP_LZ_SKIP_EN
    chk("4^13%497 op_total", 64'(mm_starts - s0), 64'd7);
`else
    chk("4^13%497 op_total", 64'(mm_starts - s0), 64'd19);
`endif

    run(16'd7, 16'd0, 16'd497, 1'b0, "exp0", r);
    chk("exp0 known", 64'(r), 64'd1);
    run(16'd7, 16'd0, 16'd1, 1'b0, "exp0_mod1", r);
    chk("exp0_mod1 known", 64'(r), 64'd0);
    run(16'd9, 16'd5, 16'd1, 1'b0, "mod1", r);

    run(16'd5, 16'd3, 16'd0, 1'b0, "mod0", r);
    chk("mod0 err_held", 64'(err), 64'd1);
    run(16'd3, 16'd4, 16'd100, 1'b0, "after_mod0", r);
    chk("after_mod0 err_cleared", 64'(err), 64'd0);

    run(16'd11, 16'd37, 16'd523, 1'b1, "held_start", r);
    run(16'd600, 16'd3, 16'd497, 1'b0, "base_gt_mod", r);

    // Abort in MUL_WAIT, then let the responder's stale mm_done arrive.
    @(negedge clk);
    base = 16'd3; exp_v = 16'hFFFF; modulus = 16'd1000; start = 1'b1;
    s0 = mm_starts;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (mm_starts - s0 >= 2) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort reached_mul", 64'(reached), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    d0 = dones;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    repeat (8) @(negedge clk);
    chk("abort no_done", 64'(dones - d0), 64'd0);
    chk("abort idle", 64'(busy), 64'd0);
    chk("abort mm_start", 64'(mm_start), 64'd0);
    run(16'd2, 16'd10, 16'd1000, 1'b0, "fresh_2^10", r);
    chk("fresh_2^10 known", 64'(r), 64'd24);

    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] rb, re, rm;
      rb = W'($urandom);
      re = W'($urandom);
      rm = (i % 3 == 0) ? W'($urandom_range(2, 50)) : W'($urandom);
      run(rb, re, rm, 1'b0, $sformatf("rand%0d", i), r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
